// File: rtl/i2c_bus_monitor.sv
// i2c_bus_monitor: observe-only I2C decoder emitting {first, ack, byte} events.
// Define I2C_MON_FIFO_EN to queue events in a FIFO_DEPTH-entry FIFO; otherwise a single output register is used.
module i2c_bus_monitor #(
   parameter int FILT_CYCLES = 3,
   parameter int FIFO_DEPTH  = 4
) (
   input  logic       ICE_CLK,
   input  logic       rst,
   input  logic       scl_in,
   input  logic       sda_in,
   output logic       ev_valid,
   input  logic       ev_ready,
   output logic [7:0] ev_data,
   output logic       ev_ack,
   output logic       ev_first,
   output logic       bus_busy,
   output logic       overflow,
   output logic       stop_seen
);
   typedef enum logic [1:0] {IDLE, DATA, ACK} state_t;
   state_t     state;
   logic [1:0] s1, s2, f, fd;   // bit 1 = SCL, bit 0 = SDA
   logic [3:0] cnt [2];
   logic [2:0] bit_cnt;
   logic [7:0] shreg;
   logic       first;
   logic       scl_rise, sda_rise, sda_fall, start, stop, push, pop;
   logic [9:0] push_ev;
   always_ff @(posedge ICE_CLK) begin
      if (rst) begin
         s1  <= 2'b11;
         s2  <= 2'b11;
         f   <= 2'b11;
         fd  <= 2'b11;
         cnt <= '{default: '0};
      end else begin
         s1 <= {scl_in, sda_in};
         s2 <= s1;
         fd <= f;
         for (int i = 0; i < 2; i++) begin
            if (s2[i] == f[i]) cnt[i] <= '0;
            else if (cnt[i] == 4'(FILT_CYCLES - 1)) begin
               f[i]   <= s2[i];
               cnt[i] <= '0;
            end else cnt[i] <= cnt[i] + 4'd1;
         end
      end
   end
   assign scl_rise = f[1] & ~fd[1];
   assign sda_rise = f[0] & ~fd[0];
   assign sda_fall = ~f[0] & fd[0];
   assign start    = sda_fall & f[1];
   assign stop     = sda_rise & f[1];
   always_ff @(posedge ICE_CLK) begin
      if (rst) begin
         state     <= IDLE;
         bit_cnt   <= '0;
         shreg     <= '0;
         first     <= 1'b0;
         bus_busy  <= 1'b0;
         stop_seen <= 1'b0;
      end else begin
         stop_seen <= stop;
         if (start) begin
            state    <= DATA;
            bit_cnt  <= '0;
            first    <= 1'b1;
            bus_busy <= 1'b1;
         end else if (stop) begin
            state    <= IDLE;
            bit_cnt  <= '0;
            bus_busy <= 1'b0;
         end else if (scl_rise && state == DATA) begin
            shreg   <= {shreg[6:0], f[0]};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) state <= ACK;
         end else if (scl_rise && state == ACK) begin
            state <= DATA;
            first <= 1'b0;
         end
      end
   end
   // the ninth SCL rise carries the ACK level straight into the event
   assign push    = scl_rise && state == ACK && !start && !stop;
   assign push_ev = {first, f[0], shreg};
   assign pop     = ev_valid && ev_ready;
`ifdef I2C_MON_FIFO_EN
   localparam int AW = $clog2(FIFO_DEPTH);
   logic [9:0]    mem [FIFO_DEPTH];
   logic [AW-1:0] wp, rp;
   logic [AW:0]   count;
   logic          full, wr;
   assign full     = count == (AW+1)'(FIFO_DEPTH);
   assign wr       = push && (!full || pop);
   assign ev_valid = count != '0;
   assign {ev_first, ev_ack, ev_data} = mem[rp];
   always_ff @(posedge ICE_CLK) begin
      if (rst) begin
         mem      <= '{default: '0};
         wp       <= '0;
         rp       <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else begin
         if (wr) begin
            mem[wp] <= push_ev;
            wp      <= wp + AW'(1);
         end
         if (pop) rp <= rp + AW'(1);
         count <= count + (AW+1)'(wr) - (AW+1)'(pop);
         if (push && full && !pop) overflow <= 1'b1;
      end
   end
`else
   logic [9:0] ev_reg;
   logic       unused_fifo_depth;
   assign unused_fifo_depth = ^FIFO_DEPTH;
   assign {ev_first, ev_ack, ev_data} = ev_reg;
   always_ff @(posedge ICE_CLK) begin
      if (rst) begin
         ev_valid <= 1'b0;
         ev_reg   <= '0;
         overflow <= 1'b0;
      end else begin
         if (push && (!ev_valid || pop)) begin
            ev_valid <= 1'b1;
            ev_reg   <= push_ev;
         end else if (pop) ev_valid <= 1'b0;
         if (push && ev_valid && !pop) overflow <= 1'b1;
      end
   end
`endif
endmodule

// File: tb/tb_i2c_bus_monitor.sv
// tb_i2c_bus_monitor: directed and randomized I2C traffic checked against a transaction-level model.
module tb_i2c_bus_monitor;
   localparam int FILT = 3;
   localparam int H    = 8;
`ifdef I2C_MON_FIFO_EN
   localparam int DEPTH = 4;
`else
   localparam int DEPTH = 1;
`endif
   logic       ICE_CLK = 1'b0, rst = 1'b1, scl_in = 1'b1, sda_in = 1'b1, ev_ready = 1'b0;
   logic       ev_valid, ev_ack, ev_first, bus_busy, overflow, stop_seen;
   logic [7:0] ev_data;
   int         errors = 0, checks = 0;
   int         nheld = 0, nstops = 0, seen_stops = 0;
   logic [9:0] exp_q[$], got_q[$];
   logic [9:0] held_ev = '0;
   logic       exp_ovf = 1'b0, first_m = 1'b0, rnd_ready = 1'b0, ready_cmd = 1'b1, hold = 1'b0;

   i2c_bus_monitor #(.FILT_CYCLES(FILT), .FIFO_DEPTH(4)) dut (
      .ICE_CLK(ICE_CLK), .rst(rst), .scl_in(scl_in), .sda_in(sda_in),
      .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_data(ev_data), .ev_ack(ev_ack),
      .ev_first(ev_first), .bus_busy(bus_busy), .overflow(overflow), .stop_seen(stop_seen)
   );

   always #5 ICE_CLK = ~ICE_CLK;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   // one clock per step: verify held outputs, drive ev_ready, log the transfer the next edge will make
   task automatic tick(input int n);
      repeat (n) begin
         @(posedge ICE_CLK);
         #1;
         if (hold && !rst) chk("stable", {22'd0, ev_valid, ev_first, ev_ack, ev_data}, {22'd0, 1'b1, held_ev});
         if (stop_seen) seen_stops++;
         ev_ready = rnd_ready ? 1'($urandom_range(0, 1)) : ready_cmd;
         if (!rst && ev_valid && ev_ready) got_q.push_back({ev_first, ev_ack, ev_data});
         hold    = !rst && ev_valid && !ev_ready;
         held_ev = {ev_first, ev_ack, ev_data};
      end
   endtask

   task automatic drive(input logic c, input logic d);
      scl_in = c;
      sda_in = d;
      tick(H);
   endtask

   task automatic mpush(input logic [9:0] ev);
      if (!rnd_ready && !ready_cmd) begin
         if (nheld < DEPTH) begin
            exp_q.push_back(ev);
            nheld++;
         end else exp_ovf = 1'b1;
      end else exp_q.push_back(ev);
   endtask

   task automatic do_start();
      drive(1, 0);
      drive(0, 0);
      first_m = 1'b1;
   endtask

   task automatic do_rstart();
      drive(0, 1);
      drive(1, 1);
      drive(1, 0);
      drive(0, 0);
      first_m = 1'b1;
   endtask

   task automatic do_stop();
      drive(0, 0);
      drive(1, 0);
      drive(1, 1);
      nstops++;
   endtask

   task automatic send_bit(input logic b);
      drive(0, b);
      drive(1, b);
      drive(0, b);
   endtask

   task automatic send_byte(input logic [7:0] d, input logic a);
      for (int i = 7; i >= 0; i--) send_bit(d[i]);
      send_bit(a);
      mpush({first_m, a, d});
      first_m = 1'b0;
   endtask

   task automatic check_events(input string tag);
      tick(40);
      chk({tag, "_count"}, got_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) chk({tag, "_event"}, 32'(got_q[i]), 32'(exp_q[i]));
      got_q.delete();
      exp_q.delete();
      chk({tag, "_overflow"}, 32'(overflow), 32'(exp_ovf));
      chk({tag, "_stops"}, seen_stops, nstops);
      chk({tag, "_busy"}, 32'(bus_busy), 0);
   endtask

   initial begin
      tick(3);
      chk("rst_valid", 32'(ev_valid), 0);
      chk("rst_data", 32'(ev_data), 0);
      chk("rst_ack", 32'(ev_ack), 0);
      chk("rst_first", 32'(ev_first), 0);
      chk("rst_busy", 32'(bus_busy), 0);
      chk("rst_overflow", 32'(overflow), 0);
      chk("rst_stop", 32'(stop_seen), 0);
      rst = 1'b0;
      tick(4);

      do_start();
      chk("busy_start", 32'(bus_busy), 1);
      send_byte(8'hA0, 0);
      send_byte(8'h55, 1);
      do_stop();
      check_events("basic");

      do_start();
      send_byte(8'hA0, 0);
      do_rstart();
      chk("busy_rstart", 32'(bus_busy), 1);
      send_byte(8'hA1, 0);
      send_byte(8'h3C, 1);
      do_stop();
      check_events("rstart");

      do_start();
      for (int i = 0; i < 3; i++) send_bit(1'b1);
      do_rstart();
      send_byte(8'h5A, 0);
      do_stop();
      check_events("partial_rstart");

      do_start();
      for (int i = 0; i < 5; i++) send_bit(1'($urandom_range(0, 1)));
      do_stop();
      check_events("stop_mid_byte");

      drive(0, 1);
      for (int i = 0; i < 9; i++) send_bit(1'($urandom_range(0, 1)));
      drive(0, 1);
      drive(1, 1);
      check_events("idle_clocks");

      sda_in = 1'b0;
      tick(FILT - 1);
      sda_in = 1'b1;
      tick(20);
      chk("glitch_busy", 32'(bus_busy), 0);
      check_events("glitch");

      sda_in = 1'b0;
      tick(FILT);
      sda_in = 1'b1;
      nstops++;
      check_events("min_pulse");

      ready_cmd = 1'b0;
      nheld = 0;
      do_start();
      for (int i = 0; i < 5; i++) send_byte(8'(8'h11 * (i + 1)), 1'(i));
      do_stop();
      tick(20);
      chk("held_valid", 32'(ev_valid), 1);
      chk("held_overflow", 32'(overflow), 1);
      ready_cmd = 1'b1;
      check_events("overflow");

      do_start();
      send_byte(8'h77, 0);
      do_stop();
      check_events("sticky");

      do_start();
      for (int i = 0; i < 4; i++) send_bit(1'b1);
      rst = 1'b1;
      tick(3);
      rst = 1'b0;
      exp_ovf = 1'b0;
      tick(2);
      chk("midrst_valid", 32'(ev_valid), 0);
      chk("midrst_overflow", 32'(overflow), 0);
      chk("midrst_busy", 32'(bus_busy), 0);
      drive(0, 1);
      drive(1, 1);
      do_start();
      send_byte(8'h12, 0);
      do_stop();
      check_events("after_rst");

      rnd_ready = 1'b1;
      for (int t = 0; t < 8; t++) begin
         int nb;
         nb = $urandom_range(1, 3);
         do_start();
         for (int b = 0; b < nb; b++) begin
            if (b > 0 && $urandom_range(0, 3) == 0) do_rstart();
            send_byte(8'($urandom), 1'($urandom_range(0, 1)));
         end
         if ($urandom_range(0, 2) == 0) begin
            int nbits;
            nbits = $urandom_range(1, 7);
            for (int k = 0; k < nbits; k++) send_bit(1'($urandom_range(0, 1)));
         end
         do_stop();
         check_events("random");
      end
      rnd_ready = 1'b0;
      tick(2);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
